// File: rtl/q_period_meter.sv
// Period and high-time meter for a single-bit Q stream. Each completed
// rise-to-rise interval is offered as a result on a valid/ready handshake.
module q_period_meter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             q_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cap;
  logic             q_d;
  logic             rise;
  logic             fall;
  logic             capture;
  logic             cnt_max;

  always_comb begin
    rise    = q_in & ~q_d;
    fall    = ~q_in & q_d;
    cnt_max = (cnt == '1);
    capture = (state == MEAS) && en && !clr && rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_cap    <= '0;
      q_d       <= 1'b0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      q_d <= q_in;

      // Result latch; clr below overrides valid/overrun since its NBAs come last.
      if (capture) begin
        if (!valid || ready) begin
          period    <= cnt;
          high_time <= hi_cap;
          valid     <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (clr) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
        timeout <= 1'b0;
        cnt     <= '0;
        state   <= en ? ARM : IDLE;
      end else if (!en) begin
        cnt   <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt    <= CNT_W'(1);
              hi_cap <= '0;
              state  <= MEAS;
            end
          end
          MEAS: begin
            if (rise) begin
              cnt    <= CNT_W'(1);
              hi_cap <= '0;
            end else if (cnt_max) begin
              timeout <= 1'b1;
              cnt     <= '0;
              state   <= ARM;
            end else begin
              cnt <= cnt + CNT_W'(1);
              if (fall) begin
                hi_cap <= cnt;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_q_period_meter.sv
// Directed bench for q_period_meter: a 16-bit instance fed by q_in with a
// result scoreboard, plus a 4-bit instance on q_s for saturation behaviour.
module tb_q_period_meter;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, q_in, q_s, ready;
  logic [15:0] period, high_time;
  logic        valid, overrun, timeout;
  logic [3:0]  period_s, high_s;
  logic        valid_s, overrun_s, timeout_s;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  bit          started;
  int          prev_hi, prev_lo;

  q_period_meter #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .q_in(q_in),
    .period(period), .high_time(high_time), .valid(valid), .ready(ready),
    .overrun(overrun), .timeout(timeout)
  );

  q_period_meter #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .q_in(q_s),
    .period(period_s), .high_time(high_s), .valid(valid_s), .ready(ready),
    .overrun(overrun_s), .timeout(timeout_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n periods of hi/lo; each rise after the first reports the previous period.
  task automatic wave(input int hi, input int lo, input int n, input bit push_en);
    for (int k = 0; k < n; k++) begin
      q_in = 1'b1;
      if (started && push_en) exp_q.push_back({16'(prev_hi + prev_lo), 16'(prev_hi)});
      started = 1'b1;
      prev_hi = hi;
      prev_lo = lo;
      repeat (hi) tick();
      q_in = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    started = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_result", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_period", 32'(period), 32'(e[31:16]));
        chk("sb_high_time", 32'(high_time), 32'(e[15:0]));
      end
    end
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; clr = 1'b0; q_in = 1'b0; q_s = 1'b0; ready = 1'b1;
    started = 1'b0; prev_hi = 0; prev_lo = 0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_high_time", 32'(high_time), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (3) tick();

    // high 2 / low 2, then high 3 / low 5 continuing the same measurement
    wave(2, 2, 4, 1'b1);
    chk("t1_drain", 32'(exp_q.size()), 32'd0);
    wave(3, 5, 3, 1'b1);
    chk("t2_drain", 32'(exp_q.size()), 32'd0);

    // consumer stalls across two further results
    do_clr();
    ready = 1'b0;
    wave(3, 3, 2, 1'b1);
    wave(1, 1, 2, 1'b0);
    chk("t3_valid_held", 32'(valid), 32'd1);
    chk("t3_period_held", 32'(period), 32'd6);
    chk("t3_high_held", 32'(high_time), 32'd3);
    chk("t3_overrun_set", 32'(overrun), 32'd1);
    ready = 1'b1;
    tick();
    chk("t3_valid_drop", 32'(valid), 32'd0);
    chk("t3_overrun_sticky", 32'(overrun), 32'd1);
    chk("t3_drain", 32'(exp_q.size()), 32'd0);
    do_clr();
    chk("t3_overrun_clr", 32'(overrun), 32'd0);

    // 4-bit instance: one rise then silence until saturation
    q_s = 1'b1;
    tick();
    q_s = 1'b0;
    repeat (14) tick();
    chk("t4_timeout_early", 32'(timeout_s), 32'd0);
    tick();
    chk("t4_timeout_set", 32'(timeout_s), 32'd1);
    chk("t4_valid_none", 32'(valid_s), 32'd0);
    q_s = 1'b1;
    tick();
    q_s = 1'b0;
    chk("t4_rearm_no_result", 32'(valid_s), 32'd0);
    repeat (2) tick();
    q_s = 1'b1;
    tick();
    q_s = 1'b0;
    chk("t4_valid_after_two", 32'(valid_s), 32'd1);
    chk("t4_period", 32'(period_s), 32'd3);
    chk("t4_high", 32'(high_s), 32'd1);
    chk("t4_timeout_sticky", 32'(timeout_s), 32'd1);
    do_clr();
    chk("t4_timeout_clr", 32'(timeout_s), 32'd0);

    // enable dropped mid-period, then re-enabled
    wave(2, 2, 2, 1'b1);
    q_in = 1'b1;
    exp_q.push_back({16'd4, 16'd2});
    tick();
    tick();
    en = 1'b0;
    tick();
    q_in = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    started = 1'b0;
    repeat (2) tick();
    wave(3, 2, 3, 1'b1);
    chk("t5_drain", 32'(exp_q.size()), 32'd0);

    // asynchronous reset while measuring with a held result
    do_clr();
    ready = 1'b0;
    wave(2, 2, 3, 1'b0);
    q_in = 1'b1;
    tick();
    chk("t6_pre_valid", 32'(valid), 32'd1);
    chk("t6_pre_overrun", 32'(overrun), 32'd1);
    chk("t6_pre_period", 32'(period), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_period", 32'(period), 32'd0);
    chk("t6_high_time", 32'(high_time), 32'd0);
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_overrun", 32'(overrun), 32'd0);
    chk("t6_timeout", 32'(timeout), 32'd0);
    q_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
